// File: rtl/mult_reconstruct.sv
// Shift-and-add inverse of the divider: rebuilds P = Q*Y + R, one multiplier bit per cycle.
// Define MULT_CHECK_EN to compare the result against x_exp and flag remainders not below the divisor.
module mult_reconstruct #(
  parameter  int QW = 3,
  parameter  int YW = 2,
  localparam int PW = QW + YW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [QW-1:0] q_in,
  input  logic [YW-1:0] y_in,
  input  logic [QW-1:0] r_in,
  input  logic [PW-2:0] x_exp,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] p,
  output logic          err
);

  localparam int CW = (YW > 1) ? $clog2(YW) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [YW-1:0] mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [PW-1:0] p_q, p_d;
  logic [PW-1:0] acc_sum;
  logic          last;

  assign acc_sum = acc_q + (mplier_q[0] ? (mcand_q << cnt_q) : '0);
  assign last    = (cnt_q == CW'(YW - 1));

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    p_d      = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = PW'(q_in);
          mplier_d = y_in;
          acc_d    = PW'(r_in);
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          p_d     = acc_sum;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      p_q      <= p_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign p    = p_q;

`ifdef MULT_CHECK_EN
  // The multiplier register shifts away, so the divisor is kept separately for the range check.
  logic [PW-2:0] x_q, x_d;
  logic [QW-1:0] r_q, r_d;
  logic [YW-1:0] y_q, y_d;
  logic          err_q, err_d;

  always_comb begin
    x_d   = x_q;
    r_d   = r_q;
    y_d   = y_q;
    err_d = err_q;
    if (state_q == IDLE && start) begin
      x_d = x_exp;
      r_d = r_in;
      y_d = y_in;
    end
    if (state_q == RUN && last) begin
      err_d = (acc_sum != {1'b0, x_q}) | (PW'(r_q) >= PW'(y_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      r_q   <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      r_q   <= r_d;
      y_q   <= y_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_x_exp;
  assign unused_x_exp = ^x_exp;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_mult_reconstruct.sv
// Directed bench for mult_reconstruct (QW=3, YW=2): latency, results, handshake and reset abort.
module tb_mult_reconstruct;

`ifdef MULT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] q_in;
  logic [1:0] y_in;
  logic [2:0] r_in;
  logic [4:0] x_exp;
  logic       busy;
  logic       done;
  logic [5:0] p;
  logic       err;

  int n_cmp  = 0;
  int n_fail = 0;

  mult_reconstruct #(.QW(3), .YW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .q_in  (q_in),
    .y_in  (y_in),
    .r_in  (r_in),
    .x_exp (x_exp),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation and waits (bounded) for done; lat counts negedges from the start negedge.
  task automatic run_op(input logic [2:0] q, input logic [1:0] y, input logic [2:0] r,
                        input logic [4:0] x, output logic [5:0] p_got, output logic err_got,
                        output int lat);
    @(negedge clk);
    q_in = q; y_in = y; r_in = r; x_exp = x; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    p_got   = p;
    err_got = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; q_in = '0; y_in = '0; r_in = '0; x_exp = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (p !== 6'd0) begin n_fail++; $display("FAIL reset_p: got %0d want 0", p); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    q_in = 3'd5; y_in = 2'd3; r_in = 3'd0; x_exp = 5'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy1: got %b want 1", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done1: got %b want 0", done); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy2: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy3: got %b want 0", busy); end
    n_cmp++; if (p !== 6'd15) begin n_fail++; $display("FAIL basic_p: got %0d want 15", p); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_fall: got %b want 0", done); end
  endtask

  task automatic test_check();
    logic [5:0] pg; logic eg; int lat;
    run_op(3'd3, 2'd2, 3'd1, 5'd7, pg, eg, lat);
    n_cmp++; if (pg !== 6'd7) begin n_fail++; $display("FAIL check_p: got %0d want 7", pg); end
    n_cmp++; if (eg !== 1'b0) begin n_fail++; $display("FAIL check_err_ok: got %b want 0", eg); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL check_lat: got %0d want 3", lat); end
    run_op(3'd3, 2'd2, 3'd1, 5'd6, pg, eg, lat);
    n_cmp++; if (pg !== 6'd7) begin n_fail++; $display("FAIL check_p2: got %0d want 7", pg); end
    n_cmp++; if (eg !== CHK) begin n_fail++; $display("FAIL check_err_bad: got %b want %b", eg, CHK); end
  endtask

  task automatic test_max();
    logic [5:0] pg; logic eg; int lat;
    run_op(3'd7, 2'd3, 3'd7, 5'd28, pg, eg, lat);
    n_cmp++; if (pg !== 6'd28) begin n_fail++; $display("FAIL max_p: got %0d want 28", pg); end
    n_cmp++; if (eg !== CHK) begin n_fail++; $display("FAIL max_err: got %b want %b", eg, CHK); end
    run_op(3'd7, 2'd0, 3'd7, 5'd7, pg, eg, lat);
    n_cmp++; if (pg !== 6'd7) begin n_fail++; $display("FAIL y0_p: got %0d want 7", pg); end
    n_cmp++; if (eg !== CHK) begin n_fail++; $display("FAIL y0_err: got %b want %b", eg, CHK); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL y0_lat: got %0d want 3", lat); end
    q_in = 3'd1; y_in = 2'd1; r_in = 3'd1;
    repeat (3) @(negedge clk);
    n_cmp++; if (p !== 6'd7) begin n_fail++; $display("FAIL p_hold: got %0d want 7", p); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    q_in = 3'd5; y_in = 2'd3; r_in = 3'd0; start = 1'b1;
    @(negedge clk);
    q_in = 3'd2; y_in = 2'd1; r_in = 3'd1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
    @(negedge clk);
    q_in = 3'd1; y_in = 2'd1; r_in = 3'd0;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_early_done: got %b want 0", done); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_cycle_busy: got %b want 0", busy); end
    n_cmp++; if (p !== 6'd15) begin n_fail++; $display("FAIL b2b_p: got %0d want 15", p); end
    q_in = 3'd6; y_in = 2'd2; r_in = 3'd1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_single_done: got %b want 0", done); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_done: got %b want 1", done); end
    n_cmp++; if (p !== 6'd13) begin n_fail++; $display("FAIL b2b_restart_p: got %0d want 13", p); end
  endtask

  task automatic test_reset_midrun();
    logic [5:0] pg; logic eg; int lat; bit saw_done;
    @(negedge clk);
    q_in = 3'd5; y_in = 2'd3; r_in = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (p !== 6'd0) begin n_fail++; $display("FAIL abort_p: got %0d want 0", p); end
    saw_done = 1'b0;
    repeat (2) begin @(negedge clk); if (done) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1'b1; end
    n_cmp++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", saw_done); end
    n_cmp++; if (p !== 6'd0) begin n_fail++; $display("FAIL abort_p_after: got %0d want 0", p); end
    run_op(3'd2, 2'd3, 3'd1, 5'd7, pg, eg, lat);
    n_cmp++; if (pg !== 6'd7) begin n_fail++; $display("FAIL post_reset_p: got %0d want 7", pg); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL post_reset_lat: got %0d want 3", lat); end
  endtask

  task automatic test_sweep();
    logic [5:0] pg, pe; logic eg, ee; int lat;
    for (int q = 0; q < 8; q++) begin
      for (int y = 1; y < 4; y++) begin
        for (int r = 0; r < 8; r++) begin
          pe = 6'(q * y + r);
          ee = CHK & (r >= y);
          run_op(3'(q), 2'(y), 3'(r), pe[4:0], pg, eg, lat);
          n_cmp++;
          if (pg !== pe) begin
            n_fail++; $display("FAIL sweep_p q=%0d y=%0d r=%0d: got %0d want %0d", q, y, r, pg, pe);
          end
          n_cmp++;
          if (lat !== 3) begin
            n_fail++; $display("FAIL sweep_lat q=%0d y=%0d r=%0d: got %0d want 3", q, y, r, lat);
          end
          n_cmp++;
          if (eg !== ee) begin
            n_fail++; $display("FAIL sweep_err q=%0d y=%0d r=%0d: got %b want %b", q, y, r, eg, ee);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_check();
    test_max();
    test_back_to_back();
    test_reset_midrun();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
